// File: rtl/cross_bar_wrr_sched.sv
// cross_bar_wrr_sched: weighted round-robin grant of one crossbar slave port among MASTER_N masters.
// Optional ack watchdog enabled by defining CROSS_BAR_WRR_TIMEOUT_EN.
module cross_bar_wrr_sched #(
    parameter int MASTER_N  = 4,
    parameter int WEIGHT_W  = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [MASTER_N-1:0]            req,
    input  logic [MASTER_N*WEIGHT_W-1:0]   weight,
    input  logic                           slave_ack,
    output logic [MASTER_N-1:0]            grant,
    output logic [$clog2(MASTER_N)-1:0]    grant_id,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int IW = $clog2(MASTER_N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic [MASTER_N-1:0]   grant_q, grant_d;
    logic [WEIGHT_W-1:0]   credit_q, credit_d;
    logic [IW-1:0]         pick;
    logic [WEIGHT_W-1:0]   wsel;
    logic                  found, cur_req, xfer, to, release_now;
    int                    j;

    assign cur_req  = req[grant_id_q];
    assign xfer     = slave_ack & cur_req;
    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == GRANT);

    // Rotating search from ptr; descending scan so the closest requester to ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        j     = 0;
        for (int i = MASTER_N - 1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % MASTER_N;
            if (req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
        wsel = weight[pick*WEIGHT_W +: WEIGHT_W];
    end

    // Next-state: grant start in IDLE, credit/abandon/watchdog release in GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        credit_d    = credit_q;
        release_now = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d    = GRANT;
                grant_d    = MASTER_N'(1) << pick;
                grant_id_d = pick;
                credit_d   = (wsel == '0) ? WEIGHT_W'(1) : wsel;
            end
        end else begin
            if (xfer && credit_q != '0)
                credit_d = credit_q - 1'b1;
            release_now = !cur_req || (xfer && credit_q == WEIGHT_W'(1)) || to;
            if (release_now) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (grant_id_q == IW'(MASTER_N - 1)) ? '0 : grant_id_q + 1'b1;
            end
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            credit_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            credit_q   <= credit_d;
        end
    end

`ifdef CROSS_BAR_WRR_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout_q;

    // Watchdog counts GRANT cycles without a completed transfer; expiry forces release.
    always_comb begin
        wd_d = wd_q;
        to   = 1'b0;
        if (state_q == IDLE || xfer) begin
            wd_d = '0;
        end else if (cur_req) begin
            wd_d = wd_q + 1'b1;
            to   = (wd_d == '1);
        end
    end

    // Watchdog registers; timeout_err pulses on the same edge the grant drops.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= to;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign to          = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
